tmr_updown_counter: RTL
=======================

# tmr_updown_counter

Parametrised successor to the single-direction TMR counter: an up/down counter with synchronous load, a programmable terminal value and a wrap-or-saturate policy. State is held in three copies, bitwise majority-voted every cycle and optionally scrubbed when idle. It sits in timer, sequencer and watchdog paths that must survive single-event upsets in their state flops.

## Interface
Parameters:
- `W`, 8, counter width in bits (≥ 2).
- `MAX`, 2**W-1, terminal value; the count range is 0..MAX, and MAX ≤ 2**W-1.
- `SAT`, 0, 0 = wrap at the range ends, 1 = saturate at the range ends.
- `SCRUB`, 1, 1 = rewrite all three copies with the voted value on idle cycles; 0 = idle copies hold.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `en`  in  1  count enable.
- `up`  in  1  direction: 1 = increment, 0 = decrement.
- `load`  in  1  synchronous load strobe; has priority over `en`.
- `load_val`  in  W  value to load.
- `count`  out  W  voted counter value.
- `tc`  out  1  terminal count flag.
- `err`  out  1  registered copy-mismatch flag.

## Operation
- State is held in three copies, `q0`, `q1` and `q2`. The voted value is `v = maj(q0,q1,q2)`, computed bitwise, and `count = v`.
- Next-state priority, evaluated on every rising edge:
  - `load`: all copies take `min(load_val, MAX)`.
  - `en & up`:
    - if `v == MAX`: the next value is MAX when `SAT=1`, else 0.
    - otherwise: the next value is `v+1`.
  - `en & !up`:
    - if `v == 0`: the next value is 0 when `SAT=1`, else MAX.
    - otherwise: the next value is `v-1`.
  - idle, `SCRUB=1`: all copies take `v`.
  - idle, `SCRUB=0`: each copy holds its own value.
- Every load or count write goes to all three copies and is computed from `v`, so one active cycle repairs any single corrupted copy.
- Arithmetic is modulo 2**W internally. Wrap and saturate are decided only by comparison against 0 and MAX, never by carry-out.
- `tc` is 1 when (`up` and `v == MAX`) or (`!up` and `v == 0`). It is combinational from `v` and `up` and is independent of `en`.
- `err` is 1 on the cycle after any cycle in which the three copies were not all equal. It is not sticky.
- Reset mid-operation forces all copies and `err` to 0 immediately, regardless of `load`/`en`.

## Timing
- Reset values: `count = 0`, `err = 0`; `tc = !up` (because MAX > 0).
- Count and load latency is 1 cycle: the new `count` is visible after the edge that samples `en`/`load`.
- Voting is combinational, with no added latency. A single upset in a copy never changes `count`.
- `err` lags the mismatch by 1 cycle.
  - With `SCRUB=1`, or any active cycle, a single upset clears on the next edge, so `err` pulses for exactly 1 cycle.
  - With `SCRUB=0` and idle, the mismatch persists and `err` stays high until the next write.
- `load` and `en` asserted in the same cycle: `load` wins and no count occurs that cycle.

## Configuration
- `TMR_CNT_ERR_EN` defined: the mismatch detector (3-way compare) and the `err` register are built.
- `TMR_CNT_ERR_EN` undefined: `err` is tied to 0 and no compare logic is synthesised. Voting and scrubbing are unchanged.

## Structure
- Shared package `tmr_pkg`:
  - `SAT_WRAP = 0` and `SAT_SAT = 1` constants.
  - The `maj3` bitwise majority function, reused by other TMR blocks.
- One sub-module, `tmr_vote3`:
  - parameterised width W.
  - inputs: the three copies.
  - outputs: voted value and mismatch flag.
  - Instantiated once. Next-state logic and the copy registers stay in `tmr_updown_counter`.

## Test plan
- W=8, MAX=9, SAT=0, up=1:
  - 12 `en` cycles from reset give `count` 1..9, 0, 1, 2.
  - `tc` is high exactly while `count == 9`.
- W=8, MAX=9, SAT=1, up=0, starting from 2:
  - 4 `en` cycles give `count` 1, 0, 0, 0.
  - `tc` stays high from the first 0 onward.
- Load boundary:
  - `load_val = 200` with MAX=9 loads 9.
  - `load` and `en` asserted together with `load_val = 3` gives `count = 3`, not 4.
- Fault injection, SCRUB=1, idle:
  - force `q1 = 8'hFF` for one edge at `count = 5`.
  - `count` stays 5, `err` pulses high for 1 cycle, and `q1` returns to 5.
- Fault injection, SCRUB=0, idle:
  - corrupt `q2`; `err` stays high.
  - the next `en` write clears `err` one cycle later.
  - a build without `TMR_CNT_ERR_EN` shows `err = 0` throughout.
- Assert `rst` mid-count at `count = 7`: `count` and `err` go to 0 asynchronously, before the next clock edge.

Source files
------------

// File: rtl/tmr_pkg.sv
// Shared TMR helpers: saturation policy constants and a bitwise 2-of-3 majority voter.
// Latency: none (constants and a combinational function only).
// Backpressure: not applicable.
package tmr_pkg;

    // Counter end-of-range policy.
    localparam int SAT_WRAP = 0;
    localparam int SAT_SAT  = 1;

    // Widest vector maj3 handles; callers zero-extend their operands and
    // truncate the result back to their own width.
    localparam int MAJ_W = 64;

    // Bitwise majority: each result bit follows at least two of the three inputs.
    function automatic logic [MAJ_W-1:0] maj3(
        input logic [MAJ_W-1:0] a,
        input logic [MAJ_W-1:0] b,
        input logic [MAJ_W-1:0] c
    );
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/tmr_vote3.sv
// Votes three state copies bitwise and flags any disagreement between them.
// Latency: combinational, zero cycles.
// Backpressure: none; this block is pure logic.
// Ports: a/b/c = the three copies, v = voted value, mismatch = copies not all equal.
// Build option TMR_CNT_ERR_EN: when undefined, mismatch is tied to 0 and no compare logic exists.
module tmr_vote3
    import tmr_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    output logic [W-1:0] v,
    output logic         mismatch
);

    assign v = W'(maj3(MAJ_W'(a), MAJ_W'(b), MAJ_W'(c)));

`ifdef TMR_CNT_ERR_EN
    // Two compares are enough: if a matches both b and c, all three agree.
    assign mismatch = (a != b) || (a != c);
`else
    assign mismatch = 1'b0;
`endif

endmodule

// File: rtl/tmr_updown_counter.sv
// Triple-redundant up/down counter with load, programmable terminal value and wrap/saturate policy.
// Latency: count/load visible 1 cycle after the sampling edge; voting adds none; err lags a mismatch by 1 cycle.
// Backpressure: none; every enabled cycle counts, load overrides en.
// Ports: clk, rst (async active-high), en, up, load, load_val[W] in; count[W], tc, err out.
// Build option TMR_CNT_ERR_EN: builds the copy-mismatch register behind err; otherwise err is tied to 0.
module tmr_updown_counter
    import tmr_pkg::*;
#(
    parameter int W     = 8,
    parameter int MAX   = 2**W - 1,
    parameter int SAT   = SAT_WRAP,
    parameter int SCRUB = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         up,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] count,
    output logic         tc,
    output logic         err
);

    localparam logic [W-1:0] MAX_V = W'(MAX);

    logic [W-1:0] q0, q1, q2;
    logic [W-1:0] v;
    logic         mismatch;
    logic [W-1:0] nxt;
    logic         wr_all;

    tmr_vote3 #(.W(W)) u_vote (
        .a        (q0),
        .b        (q1),
        .c        (q2),
        .v        (v),
        .mismatch (mismatch)
    );

    assign count = v;
    assign tc    = up ? (v == MAX_V) : (v == '0);

    // Every write is derived from the voted value and lands in all three
    // copies, so any write cycle repairs a single corrupted copy.
    always_comb begin
        nxt    = v;
        wr_all = 1'b1;
        if (load) begin
            nxt = (load_val > MAX_V) ? MAX_V : load_val;
        end else if (en && up) begin
            if (v == MAX_V) nxt = (SAT == SAT_SAT) ? MAX_V : '0;
            else            nxt = v + 1'b1;
        end else if (en) begin
            if (v == '0) nxt = (SAT == SAT_SAT) ? '0 : MAX_V;
            else         nxt = v - 1'b1;
        end else begin
            // Idle: scrubbing rewrites the voted value, otherwise copies hold.
            wr_all = (SCRUB != 0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q0 <= '0;
            q1 <= '0;
            q2 <= '0;
        end else if (wr_all) begin
            q0 <= nxt;
            q1 <= nxt;
            q2 <= nxt;
        end
    end

`ifdef TMR_CNT_ERR_EN
    logic err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= mismatch;
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule
